ram_s3board_arb: RTL
====================

// Module: ram_s3board_arb
// PURPOSE
//  Two-port arbiter and cycle sequencer for the s3board 256Kx16 async SRAM pair.
//  Port 0 (CPU) and port 1 (DMA/console) issue 12-bit PDP-8 word reads and writes
//  into a 32K-word space. The block grants one port at a time (round-robin).
//  It drives ram1 strobes with fixed setup/access/hold timing. ram2 is held deselected.
// PARAMETERS
//  ADDR_W       15  word address width; ram_a[17:ADDR_W] driven 0
//  DATA_W       12  word width; stored in ram1_io[DATA_W-1:0]
//  WAIT_STATES   1  extra ACCESS cycles; ACCESS lasts WAIT_STATES+1 cycles
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  reset_n    in   1       synchronous, active-low reset
//  r0_req     in   1       port 0 request level; hold with operands until r0_ack
//  r0_wr      in   1       port 0: 1=write, 0=read
//  r0_addr    in   ADDR_W  port 0 word address
//  r0_wdata   in   DATA_W  port 0 write data
//  r0_ack     out  1       port 0 one-cycle completion pulse
//  r1_req/r1_wr/r1_addr/r1_wdata/r1_ack  same as port 0, for port 1
//  rdata      out  DATA_W  read data; valid in the ack cycle, held until next read
//  busy       out  1       high in every state except IDLE
//  parity_err out  1       read parity failure flag (SRAM_PARITY_EN only)
//  ram_a      out  18      SRAM address
//  ram_oe_n   out  1       SRAM output enable, shared by both chips
//  ram_we_n   out  1       SRAM write enable, shared by both chips
//  ram1_io    inout 16     ram1 data bus
//  ram1_ce_n/ram1_ub_n/ram1_lb_n  out 1  ram1 chip and byte enables
//  ram2_ce_n/ram2_ub_n/ram2_lb_n  out 1  always 1 (ram2 unused)
// BEHAVIOUR
//  All outputs and the bus are registered. Reset values: ram_a=0; all *_n=1;
//   ram1_io=Z; acks=0; rdata=0; busy=0; parity_err=0; state=IDLE; last_grant=1.
//  FSM: IDLE -> SETUP -> ACCESS (x WAIT_STATES+1) -> HOLD -> IDLE.
//  IDLE: no req -> stay. Exactly one req -> grant that port.
//   Both req -> grant the port != last_grant; last_grant <= granted port.
//   Granted addr/wr/wdata are latched internally on the grant edge.
//  SETUP: ram_a=addr; ram1_ce_n/ub_n/lb_n=0; we_n=1.
//   Read: oe_n=0. Write: oe_n=1, ram1_io driven with wdata.
//  ACCESS: write -> we_n=0 for every ACCESS cycle. Read -> oe_n stays 0.
//   Read data is sampled into rdata on the last ACCESS edge.
//  HOLD: we_n=1; ce_n, addr and write data held (no hold violation). oe_n=1.
//   The granted port's ack is 1 for this single cycle.
//  Next edge: ce_n/ub_n/lb_n=1, bus=Z, state IDLE.
//  Latency (req sampled in IDLE cycle 0): ack high in cycle WAIT_STATES+3.
//   With the default, ack is high in cycle 4. Throughput: one word per WAIT_STATES+4 cycles.
//  Requester drops req (or presents a new op) the cycle after ack.
//   A req still high in the IDLE cycle after ack is a new transaction.
//  Operand changes while req is pending but ungranted are legal; changes after grant are ignored.
//  Write data: bits [DATA_W-1:0]=wdata; bits [15:DATA_W]=0 (bit 12 see CONFIG).
//  ram1_io is driven only from SETUP through HOLD of a write, never while oe_n=0.
//  Reset mid-transaction: next edge forces reset values. No ack is issued; the write may be partial.
// CONFIGURATION
//  SRAM_PARITY_EN defined:
//   Write puts odd parity of wdata on ram1_io[12].
//   Read compares ram1_io[12] with recomputed parity on the capture edge.
//   A mismatch sets parity_err. parity_err is sticky until reset; rdata is still returned.
//  SRAM_PARITY_EN undefined: ram1_io[12] written 0; parity_err tied 0; bit 12 ignored on read.
// TESTING
//  1. r0 write addr 0o00200 data 0o7402, then read -> ack in cycle 4.
//     we_n low exactly 2 cycles; rdata=0o7402.
//  2. r0 and r1 req same cycle after reset -> r0 granted first, r1 next.
//     Both req held continuously -> grants alternate 0,1,0,1.
//  3. r1 read 0o77777 (top of space) -> ram_a=18'o077777, ram_a[17:15]=0.
//     ram2_ce_n stays 1 throughout.
//  4. reset_n low during ACCESS of a write -> next edge: all strobes 1, bus Z.
//     No ack; busy=0.
//  5. WAIT_STATES=3 build -> ACCESS lasts 4 cycles; ack in cycle 6.
//  6. SRAM_PARITY_EN: write 0o1234, force bit 12 flip in SRAM model, read.
//     -> parity_err=1 and stays 1; rdata=0o1234.

Source files
------------

// File: rtl/ram_s3board_arb.sv
// ---------------------------------------------------------------------------
// ram_s3board_arb
//
// Two-port round-robin arbiter and cycle sequencer for the s3board 256Kx16
// asynchronous SRAM pair.
//
// Port 0 (CPU) and port 1 (DMA/console) issue 12-bit word reads and writes
// into a 32K-word space. Only ram1 is used; ram2 is held deselected.
// Each transaction walks IDLE -> SETUP -> ACCESS (WAIT_STATES+1 cycles) ->
// HOLD -> IDLE. The requester sees a one-cycle ack in the HOLD cycle.
//
// Optional feature macro: SRAM_PARITY_EN
//   defined   : odd parity of the write data is stored in ram1_io[12] and
//               checked on every read; a mismatch sets the sticky parity_err.
//   undefined : ram1_io[12] is written 0 and ignored; parity_err is tied 0.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   rN_req/rN_wr/rN_addr/rN_wdata  port N request level and operands
//   rN_ack                       port N one-cycle completion pulse
//   rdata                        read data, valid in the ack cycle, held
//   busy                         high in every state except IDLE
//   parity_err                   sticky read parity failure flag
//   ram_a, ram_oe_n, ram_we_n    shared SRAM address / strobes
//   ram1_io                      ram1 16-bit bidirectional data bus
//   ram1_ce_n/ub_n/lb_n          ram1 chip and byte enables
//   ram2_ce_n/ub_n/lb_n          ram2 enables, always 1
// ---------------------------------------------------------------------------
module ram_s3board_arb #(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              r0_req,
    input  logic              r0_wr,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    input  logic              r1_req,
    input  logic              r1_wr,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              parity_err,
    output logic [17:0]       ram_a,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    inout  wire  [15:0]       ram1_io,
    output logic              ram1_ce_n,
    output logic              ram1_ub_n,
    output logic              ram1_lb_n,
    output logic              ram2_ce_n,
    output logic              ram2_ub_n,
    output logic              ram2_lb_n
);

    localparam int CNT_W = $clog2(WAIT_STATES + 2) + 1;
    localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

`ifdef SRAM_PARITY_EN
    // Odd parity: the stored parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [DATA_W-1:0] d);
        return ~(^d);
    endfunction
`endif

    // Forms the 16-bit bus word: data in the low bits, upper bits zero,
    // bit 12 carries parity when that feature is built in.
    function automatic logic [15:0] pack_word(input logic [DATA_W-1:0] d);
        logic [15:0] w;
        w = 16'(d);
`ifdef SRAM_PARITY_EN
        w[12] = odd_parity(d);
`endif
        return w;
    endfunction

    state_t            state_r;
    state_t            next_state_s;
    logic [CNT_W-1:0]  acc_cnt_r;
    logic              last_grant_r;
    logic              grant_r;
    logic              op_wr_r;

    logic              grant_s;
    logic              sel_wr_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              cur_wr_s;
    logic              start_s;
    logic              capture_s;

    logic              ce_n_d_s;
    logic              oe_n_d_s;
    logic              we_n_d_s;
    logic              drive_d_s;
    logic              ack0_d_s;
    logic              ack1_d_s;
    logic              busy_d_s;

    logic [17:0]       ram_a_r;
    logic              ram_oe_n_r;
    logic              ram_we_n_r;
    logic              ram1_ce_n_r;
    logic              io_drive_r;
    logic [15:0]       io_dout_r;
    logic              r0_ack_r;
    logic              r1_ack_r;
    logic [DATA_W-1:0] rdata_r;
    logic              busy_r;
    logic              unused_io_s;

    // Round-robin choice: a lone requester wins, a tie goes to the port
    // that was not granted last time.
    always_comb begin
        grant_s = 1'b0;
        if (r0_req && r1_req) begin
            grant_s = ~last_grant_r;
        end else if (r1_req) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Operands of the port being granted; only meaningful in IDLE.
    always_comb begin
        sel_wr_s    = 1'b0;
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_wdata_s = {DATA_W{1'b0}};
        if (grant_s) begin
            sel_wr_s    = r1_wr;
            sel_addr_s  = r1_addr;
            sel_wdata_s = r1_wdata;
        end else begin
            sel_wr_s    = r0_wr;
            sel_addr_s  = r0_addr;
            sel_wdata_s = r0_wdata;
        end
    end

    // Direction of the transaction in flight (or about to start).
    always_comb begin
        cur_wr_s = 1'b0;
        if (state_r == ST_IDLE) begin
            cur_wr_s = sel_wr_s;
        end else begin
            cur_wr_s = op_wr_r;
        end
    end

    assign start_s   = (state_r == ST_IDLE) && (r0_req || r1_req);
    // Read data is captured on the edge that leaves the last ACCESS cycle.
    assign capture_s = (state_r == ST_ACCESS) && (acc_cnt_r == ACC_LAST) && !op_wr_r;

    // State register, access-cycle counter, latched direction and fairness pointer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            acc_cnt_r    <= {CNT_W{1'b0}};
            last_grant_r <= 1'b1;
            grant_r      <= 1'b0;
            op_wr_r      <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_ACCESS) begin
                acc_cnt_r <= acc_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                acc_cnt_r <= {CNT_W{1'b0}};
            end
            if (start_s) begin
                grant_r      <= grant_s;
                last_grant_r <= grant_s;
                op_wr_r      <= sel_wr_s;
            end
        end
    end

    // Next-state logic of the access sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (r0_req || r1_req) begin
                    next_state_s = ST_SETUP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                next_state_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (acc_cnt_r == ACC_LAST) begin
                    next_state_s = ST_HOLD;
                end else begin
                    next_state_s = ST_ACCESS;
                end
            end
            ST_HOLD: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Strobe values for the coming state; registered below so every pin
    // changes cleanly on the clock edge together with the state.
    always_comb begin
        ce_n_d_s  = 1'b1;
        oe_n_d_s  = 1'b1;
        we_n_d_s  = 1'b1;
        drive_d_s = 1'b0;
        ack0_d_s  = 1'b0;
        ack1_d_s  = 1'b0;
        busy_d_s  = 1'b1;
        case (next_state_s)
            ST_IDLE: begin
                busy_d_s = 1'b0;
            end
            ST_SETUP: begin
                ce_n_d_s  = 1'b0;
                oe_n_d_s  = cur_wr_s;
                drive_d_s = cur_wr_s;
            end
            ST_ACCESS: begin
                ce_n_d_s  = 1'b0;
                oe_n_d_s  = cur_wr_s;
                we_n_d_s  = ~cur_wr_s;
                drive_d_s = cur_wr_s;
            end
            ST_HOLD: begin
                // we_n already high; address, ce_n and data stay put for hold time.
                ce_n_d_s  = 1'b0;
                drive_d_s = cur_wr_s;
                ack0_d_s  = ~grant_r;
                ack1_d_s  = grant_r;
            end
            default: begin
                busy_d_s = 1'b0;
            end
        endcase
    end

    // Output and bus registers; address and write word are latched at grant.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ram_a_r     <= 18'd0;
            ram_oe_n_r  <= 1'b1;
            ram_we_n_r  <= 1'b1;
            ram1_ce_n_r <= 1'b1;
            io_drive_r  <= 1'b0;
            io_dout_r   <= 16'h0000;
            r0_ack_r    <= 1'b0;
            r1_ack_r    <= 1'b0;
            rdata_r     <= {DATA_W{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            ram_oe_n_r  <= oe_n_d_s;
            ram_we_n_r  <= we_n_d_s;
            ram1_ce_n_r <= ce_n_d_s;
            io_drive_r  <= drive_d_s;
            r0_ack_r    <= ack0_d_s;
            r1_ack_r    <= ack1_d_s;
            busy_r      <= busy_d_s;
            if (start_s) begin
                ram_a_r   <= 18'(sel_addr_s);
                io_dout_r <= pack_word(sel_wdata_s);
            end
            if (capture_s) begin
                rdata_r <= ram1_io[DATA_W-1:0];
            end
        end
    end

`ifdef SRAM_PARITY_EN
    logic parity_err_r;

    // Sticky parity flag, evaluated on the read capture edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            parity_err_r <= 1'b0;
        end else if (capture_s && (ram1_io[12] != odd_parity(ram1_io[DATA_W-1:0]))) begin
            parity_err_r <= 1'b1;
        end
    end

    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

    // Upper bus bits carry no data on read.
    assign unused_io_s = ^ram1_io[15:DATA_W];

    assign ram1_io   = io_drive_r ? io_dout_r : 16'bz;
    assign ram_a     = ram_a_r;
    assign ram_oe_n  = ram_oe_n_r;
    assign ram_we_n  = ram_we_n_r;
    assign ram1_ce_n = ram1_ce_n_r;
    assign ram1_ub_n = ram1_ce_n_r;
    assign ram1_lb_n = ram1_ce_n_r;
    assign ram2_ce_n = 1'b1;
    assign ram2_ub_n = 1'b1;
    assign ram2_lb_n = 1'b1;
    assign r0_ack    = r0_ack_r;
    assign r1_ack    = r1_ack_r;
    assign rdata     = rdata_r;
    assign busy      = busy_r;

endmodule
